note_lane_queue: RTL and testbench

NOTE_LANE_QUEUE -- requirements
Module: note_lane_queue

---
 rtl/note_lane_queue.sv | 187 ++++++++++++++++++
 tb/tb_note_lane_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/note_lane_queue.sv
// note_lane_queue: per-lane circular note queues for a rhythm-game judge.
// Each lane keeps a ring of DEPTH note slots. A spawn allocates the slot at the
// head and a hit or expiry retires the slot at the tail. The queues are updated
// only on frame ticks, and every output is registered.
//
// Optional feature: define NOTE_LANE_SCORE_EN to build the combo and score
// accumulators. Without it, combo and score are tied to 0.
//
// Ports:
//   clk         system clock; all state changes on its rising edge
//   rst         asynchronous, active-low reset
//   tick        one-clk frame strobe that qualifies all queue events
//   spawn       per-lane request to allocate a note at the head
//   expired     per-lane: the oldest note passed the judgement window
//   good_hit    per-lane: the oldest note was hit in the good window
//   ok_hit      per-lane: the oldest note was hit in the ok window
//   slot_valid  bit [l*DEPTH+s] is set while slot s of lane l holds a note
//   init_valid  one-clk pulse per lane after a slot is allocated
//   init_idx    per-lane index of the slot just allocated
//   count       per-lane occupancy, 0..DEPTH
//   overflow    per-lane sticky flag: a spawn was dropped because the lane was full
//   judge_good, judge_ok, judge_miss   one-clk judgement pulses
//   combo       consecutive-hit count, saturating at 1023
//   score       accumulated score, saturating at 65535
module note_lane_queue #(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [LANES-1:0]           spawn,
  input  logic [LANES-1:0]           expired,
  input  logic [LANES-1:0]           good_hit,
  input  logic [LANES-1:0]           ok_hit,
  output logic [LANES*DEPTH-1:0]     slot_valid,
  output logic [LANES-1:0]           init_valid,
  output logic [LANES*PTR_W-1:0]     init_idx,
  output logic [LANES*(PTR_W+1)-1:0] count,
  output logic [LANES-1:0]           overflow,
  output logic                       judge_good,
  output logic                       judge_ok,
  output logic                       judge_miss,
  output logic [9:0]                 combo,
  output logic [15:0]                score
);

  localparam int unsigned CW = PTR_W + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Low for the first clk edge after reset release, so a tick that coincides
  // with deassertion is discarded.
  logic live;
  logic go;

  logic [PTR_W-1:0] head [LANES];
  logic [PTR_W-1:0] tail [LANES];

  logic [LANES-1:0]       acc_spawn;
  logic [LANES-1:0]       acc_ret;
  logic [LANES-1:0]       ret_good;
  logic [LANES-1:0]       ret_ok;
  logic [LANES-1:0]       ret_miss;
  logic [LANES-1:0]       ovf_set;
  logic [LANES*DEPTH-1:0] slot_next;

  assign go = tick & live;

  // Clear the tail slot first, then set the head slot. When a full lane spawns
  // and retires in the same tick, head equals tail and the slot stays occupied.
  function automatic logic [DEPTH-1:0] lane_upd(
    input logic [DEPTH-1:0] v,
    input logic [PTR_W-1:0] t,
    input logic [PTR_W-1:0] h,
    input logic             r,
    input logic             s
  );
    logic [DEPTH-1:0] n;
    n = v;
    if (r) n[t] = 1'b0;
    if (s) n[h] = 1'b1;
    return n;
  endfunction

  // Per-lane event decode. Retire cause priority is good, then ok, then
  // expired. A full lane accepts a spawn only when it also retires a note.
  always_comb begin
    acc_spawn = '0;
    acc_ret   = '0;
    ret_good  = '0;
    ret_ok    = '0;
    ret_miss  = '0;
    ovf_set   = '0;
    slot_next = slot_valid;
    for (int l = 0; l < LANES; l++) begin
      acc_ret[l]   = go & (good_hit[l] | ok_hit[l] | expired[l])
                     & (count[l*CW +: CW] != '0);
      ret_good[l]  = acc_ret[l] & good_hit[l];
      ret_ok[l]    = acc_ret[l] & ~good_hit[l] & ok_hit[l];
      ret_miss[l]  = acc_ret[l] & ~good_hit[l] & ~ok_hit[l] & expired[l];
      acc_spawn[l] = go & spawn[l] & ((count[l*CW +: CW] != FULL) | acc_ret[l]);
      ovf_set[l]   = go & spawn[l] & (count[l*CW +: CW] == FULL) & ~acc_ret[l];
      slot_next[l*DEPTH +: DEPTH] = lane_upd(slot_valid[l*DEPTH +: DEPTH],
                                             tail[l], head[l],
                                             acc_ret[l], acc_spawn[l]);
    end
  end

  // Queue state, allocation pulses and judgement pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live       <= 1'b0;
      slot_valid <= '0;
      init_valid <= '0;
      init_idx   <= '0;
      count      <= '0;
      overflow   <= '0;
      judge_good <= 1'b0;
      judge_ok   <= 1'b0;
      judge_miss <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        head[l] <= '0;
        tail[l] <= '0;
      end
    end else begin
      live       <= 1'b1;
      slot_valid <= slot_next;
      init_valid <= acc_spawn;
      overflow   <= overflow | ovf_set;
      judge_good <= |ret_good;
      judge_ok   <= |ret_ok;
      judge_miss <= |ret_miss;
      for (int l = 0; l < LANES; l++) begin
        if (acc_spawn[l]) begin
          head[l]                      <= head[l] + PTR_W'(1);
          init_idx[l*PTR_W +: PTR_W]   <= head[l];
        end
        if (acc_ret[l]) tail[l] <= tail[l] + PTR_W'(1);
        if (acc_spawn[l] && !acc_ret[l])
          count[l*CW +: CW] <= count[l*CW +: CW] + CW'(1);
        else if (!acc_spawn[l] && acc_ret[l])
          count[l*CW +: CW] <= count[l*CW +: CW] - CW'(1);
      end
    end
  end

`ifdef NOTE_LANE_SCORE_EN
  localparam int unsigned NW = 4;

  logic [NW-1:0] n_good;
  logic [NW-1:0] n_ok;
  logic [10:0]   combo_sum;
  logic [16:0]   score_sum;

  // Count this tick's good and ok retires across lanes and form the
  // unsaturated next combo and score.
  always_comb begin
    n_good = '0;
    n_ok   = '0;
    for (int l = 0; l < LANES; l++) begin
      n_good = n_good + NW'(ret_good[l]);
      n_ok   = n_ok + NW'(ret_ok[l]);
    end
    combo_sum = {1'b0, combo} + 11'(n_good) + 11'(n_ok);
    score_sum = {1'b0, score} + 17'(n_good) * 17'd300 + 17'(n_ok) * 17'd100;
  end

  // Saturating accumulators. Any miss in a tick resets the combo.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      combo <= '0;
      score <= '0;
    end else begin
      if (|ret_miss)                combo <= '0;
      else if (combo_sum > 11'd1023) combo <= 10'd1023;
      else                          combo <= combo_sum[9:0];
      if (score_sum > 17'd65535) score <= 16'hFFFF;
      else                       score <= score_sum[15:0];
    end
  end
`else
  assign combo = '0;
  assign score = '0;
`endif

endmodule

// File: tb/tb_note_lane_queue.sv
// Directed bench for note_lane_queue (LANES=2, DEPTH=8). The expected combo and
// score follow the NOTE_LANE_SCORE_EN build option.
module tb_note_lane_queue;

`ifdef NOTE_LANE_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        tick;
  logic [1:0]  spawn, expired, good_hit, ok_hit;
  logic [15:0] slot_valid;
  logic [1:0]  init_valid;
  logic [5:0]  init_idx;
  logic [7:0]  count;
  logic [1:0]  overflow;
  logic        judge_good, judge_ok, judge_miss;
  logic [9:0]  combo;
  logic [15:0] score;

  int n_chk  = 0;
  int n_fail = 0;
  int e_combo = 0;
  int e_score = 0;

  note_lane_queue #(.LANES(2), .DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .spawn(spawn), .expired(expired), .good_hit(good_hit), .ok_hit(ok_hit),
    .slot_valid(slot_valid), .init_valid(init_valid), .init_idx(init_idx),
    .count(count), .overflow(overflow),
    .judge_good(judge_good), .judge_ok(judge_ok), .judge_miss(judge_miss),
    .combo(combo), .score(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one tick cycle, then sample 1 ns after the capturing edge.
  task automatic step(input logic [1:0] sp, input logic [1:0] ex,
                      input logic [1:0] gd, input logic [1:0] okh);
    @(negedge clk);
    spawn = sp; expired = ex; good_hit = gd; ok_hit = okh; tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0; spawn = '0; expired = '0; good_hit = '0; ok_hit = '0;
  endtask

  // Reference combo/score update for one tick.
  task automatic model(input int ng, input int no, input bit miss);
    if (SCORE_EN) begin
      if (miss) e_combo = 0;
      else e_combo = (e_combo + ng + no > 1023) ? 1023 : e_combo + ng + no;
      e_score = (e_score + 300*ng + 100*no > 65535) ? 65535 : e_score + 300*ng + 100*no;
    end
  endtask

  task automatic check_acc(input string tag);
    check({tag, "_combo"}, 32'(combo), 32'(e_combo));
    check({tag, "_score"}, 32'(score), 32'(e_score));
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0;
    spawn = '0; expired = '0; good_hit = '0; ok_hit = '0;

    // Reset state
    #12;
    check("rst_count", 32'(count), 32'h0);
    check("rst_slots", 32'(slot_valid), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_init", 32'(init_valid), 32'h0);
    check("rst_judge", 32'({judge_good, judge_ok, judge_miss}), 32'h0);
    check_acc("rst");

    // Tick coincident with reset release is discarded
    #5; spawn = 2'b01; tick = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; spawn = '0;
    check("rel_count", 32'(count), 32'h0);
    check("rel_init", 32'(init_valid), 32'h0);

    // Lane 0: three spawns allocate slots 0,1,2
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 2'b00, 2'b00, 2'b00);
      check("l0_init_valid", 32'(init_valid), 32'h1);
      check("l0_init_idx", 32'(init_idx[2:0]), 32'(i));
    end
    check("l0_count3", 32'(count[3:0]), 32'h3);
    check("l0_slots3", 32'(slot_valid[7:0]), 32'h07);

    // Spawn without tick is ignored
    @(negedge clk); spawn = 2'b01;
    @(posedge clk); #1; spawn = '0;
    check("notick_count", 32'(count[3:0]), 32'h3);
    check("notick_init", 32'(init_valid), 32'h0);

    // Lane 1: fill to 8, 9th spawn dropped with sticky overflow
    for (int i = 0; i < 8; i++) step(2'b10, 2'b00, 2'b00, 2'b00);
    check("l1_count8", 32'(count[7:4]), 32'h8);
    check("l1_slots", 32'(slot_valid[15:8]), 32'hFF);
    check("l1_idx7", 32'(init_idx[5:3]), 32'h7);
    check("l1_ovf0", 32'(overflow), 32'h0);
    step(2'b10, 2'b00, 2'b00, 2'b00);
    check("l1_drop_count", 32'(count[7:4]), 32'h8);
    check("l1_drop_ovf", 32'(overflow), 32'h2);
    check("l1_drop_init", 32'(init_valid), 32'h0);
    // Full lane spawn + expired: accepted, head wrapped to slot 0
    step(2'b10, 2'b10, 2'b00, 2'b00);
    model(0, 0, 1'b1);
    check("l1_wrap_count", 32'(count[7:4]), 32'h8);
    check("l1_wrap_init", 32'(init_valid), 32'h2);
    check("l1_wrap_idx", 32'(init_idx[5:3]), 32'h0);
    check("l1_wrap_judge", 32'({judge_good, judge_ok, judge_miss}), 32'h1);
    check("l1_ovf_sticky", 32'(overflow), 32'h2);

    // Lane 0: fill to 8, then spawn + good in one tick
    for (int i = 0; i < 5; i++) step(2'b01, 2'b00, 2'b00, 2'b00);
    check("l0_count8", 32'(count[3:0]), 32'h8);
    check("l0_slots8", 32'(slot_valid[7:0]), 32'hFF);
    step(2'b01, 2'b00, 2'b01, 2'b00);
    model(1, 0, 1'b0);
    check("sg_count", 32'(count[3:0]), 32'h8);
    check("sg_idx", 32'(init_idx[2:0]), 32'h0);
    check("sg_judge", 32'({judge_good, judge_ok, judge_miss}), 32'h4);
    check_acc("sg");
    // Tail is now 1: next good clears slot 1
    step(2'b00, 2'b00, 2'b01, 2'b00);
    model(1, 0, 1'b0);
    check("tail1_slots", 32'(slot_valid[7:0]), 32'hFD);
    check("tail1_count", 32'(count[3:0]), 32'h7);
    check_acc("tail1");

    // Good on lane 0 and expired on lane 1 in the same tick
    step(2'b00, 2'b10, 2'b01, 2'b00);
    model(1, 0, 1'b1);
    check("gm_judge", 32'({judge_good, judge_ok, judge_miss}), 32'h5);
    check("gm_slots", 32'(slot_valid), 32'hFDF9);
    check("gm_count", 32'(count), 32'h76);
    check_acc("gm");

    // Cause priority: lane 0 good>ok>expired, lane 1 ok>expired
    step(2'b00, 2'b11, 2'b01, 2'b11);
    model(1, 1, 1'b0);
    check("pri_judge", 32'({judge_good, judge_ok, judge_miss}), 32'h6);
    check("pri_count", 32'(count), 32'h65);
    check_acc("pri");

    // Asynchronous reset mid-queue (lane 0 count=5)
    check("pre_rst_count0", 32'(count[3:0]), 32'h5);
    @(negedge clk); #2; rst = 1'b0; #1;
    e_combo = 0; e_score = 0;
    check("arst_count", 32'(count), 32'h0);
    check("arst_slots", 32'(slot_valid), 32'h0);
    check("arst_ovf", 32'(overflow), 32'h0);
    check("arst_idx", 32'(init_idx), 32'h0);
    check_acc("arst");
    @(negedge clk); #1; rst = 1'b1;
    step(2'b01, 2'b00, 2'b00, 2'b00);
    check("post_rst_idx", 32'(init_idx[2:0]), 32'h0);
    check("post_rst_count", 32'(count[3:0]), 32'h1);

    // Retire events on an empty lane are ignored
    step(2'b00, 2'b10, 2'b00, 2'b00);
    check("empty_miss", 32'({judge_good, judge_ok, judge_miss}), 32'h0);
    check("empty_count", 32'(count[7:4]), 32'h0);
    step(2'b00, 2'b00, 2'b10, 2'b00);
    check("empty_good", 32'({judge_good, judge_ok, judge_miss}), 32'h0);
    check_acc("empty");

    // Combo and score saturation with two good hits per tick
    step(2'b11, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 520; i++) begin
      step(2'b11, 2'b00, 2'b11, 2'b00);
      model(2, 0, 1'b0);
      if (i == 99) check_acc("mid_sat");
    end
    check("sat_count", 32'(count), 32'h12);
    check_acc("sat");
    step(2'b11, 2'b00, 2'b11, 2'b00);
    model(2, 0, 1'b0);
    check_acc("sat_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
